// File: rtl/pipe_pkg.sv
// Shared defaults and types for the multiply-add pipe and its result collector.
package pipe_pkg;

  localparam int PIPE_DATA_W    = 8;
  localparam int PIPE_FRAME_LEN = 4;

  typedef logic [PIPE_DATA_W-1:0] result_t;

endpackage : pipe_pkg

// File: rtl/pipe_result_fifo.sv
// Result FIFO: storage, wrapping pointers and an exact occupancy count.
// The head word is presented combinationally and reads as zero while empty.
module pipe_result_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  // Storage carries no reset; stale entries are never visible because the
  // head output is masked whenever the count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_CNT);
  assign count   = count_reg;
  assign rd_data = empty ? '0 : mem[rd_ptr_reg];

endmodule : pipe_result_fifo

// File: rtl/pipe_result_collector.sv
// Collects pipe results into a FIFO, drains them with frame tagging and flags drops.
// Optional per-frame sum outputs are enabled by defining PIPE_RESULT_COLLECTOR_SUM_EN.
module pipe_result_collector
  import pipe_pkg::*;
#(
  parameter int DATA_W    = PIPE_DATA_W,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = PIPE_FRAME_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_overflow
`ifdef PIPE_RESULT_COLLECTOR_SUM_EN
  ,
  output logic [DATA_W+$clog2(FRAME_LEN)-1:0] frame_sum,
  output logic                                frame_sum_valid
`endif
);

  localparam int FCNT_W = $clog2(FRAME_LEN);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAME_LEN - 1);

  logic              push;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              frame_end;
  logic              overflow_reg, overflow_next;
  logic [FCNT_W-1:0] fcnt_reg, fcnt_next;

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!fifo_full || pop);
  assign drop = in_valid && !push;

  pipe_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (out_data),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign frame_end = (fcnt_reg == FCNT_LAST);
  assign out_last  = out_valid && frame_end;
  assign overflow  = overflow_reg;

  always_comb begin
    overflow_next = overflow_reg;
    fcnt_next     = fcnt_reg;
    // A drop takes priority over a simultaneous clear.
    if (clr_overflow) begin
      overflow_next = 1'b0;
    end
    if (drop) begin
      overflow_next = 1'b1;
    end
    if (pop) begin
      fcnt_next = frame_end ? '0 : fcnt_reg + FCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
      fcnt_reg     <= '0;
    end else begin
      overflow_reg <= overflow_next;
      fcnt_reg     <= fcnt_next;
    end
  end

`ifdef PIPE_RESULT_COLLECTOR_SUM_EN
  localparam int SUM_W = DATA_W + FCNT_W;

  logic [SUM_W-1:0] acc_reg, acc_next;
  logic [SUM_W-1:0] frame_sum_reg, frame_sum_next;
  logic             frame_sum_valid_reg, frame_sum_valid_next;
  logic [SUM_W-1:0] acc_plus_head;

  assign acc_plus_head = acc_reg + SUM_W'(out_data);

  always_comb begin
    acc_next             = acc_reg;
    frame_sum_next       = frame_sum_reg;
    frame_sum_valid_next = 1'b0;
    if (pop) begin
      if (frame_end) begin
        frame_sum_next       = acc_plus_head;
        frame_sum_valid_next = 1'b1;
        acc_next             = '0;
      end else begin
        acc_next = acc_plus_head;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg             <= '0;
      frame_sum_reg       <= '0;
      frame_sum_valid_reg <= 1'b0;
    end else begin
      acc_reg             <= acc_next;
      frame_sum_reg       <= frame_sum_next;
      frame_sum_valid_reg <= frame_sum_valid_next;
    end
  end

  assign frame_sum       = frame_sum_reg;
  assign frame_sum_valid = frame_sum_valid_reg;
`endif

endmodule : pipe_result_collector
